// File: rtl/sel_pkg.sv
// -----------------------------------------------------------------------------
// sel_pkg
// Shared types and constants for the selector sequencer.
//   SEL_W       : selector width (codes 0..6 are decoded downstream, 7 is not)
//   CNT_W       : repeat-count width (count N means N+1 beats)
//   SEL_ILLEGAL : the one selector code the downstream decode does not map
//   sel_cmd_t   : one buffered command {sel, count}
//   sel_state_t : sequencer FSM state
// -----------------------------------------------------------------------------
package sel_pkg;

    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 8;

    localparam logic [SEL_W-1:0]  SEL_ILLEGAL = 3'd7;
    localparam logic [DROP_W-1:0] DROP_MAX    = 8'hFF;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [CNT_W-1:0] count;
    } sel_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sel_state_t;

    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
        return sel != SEL_ILLEGAL;
    endfunction

endpackage

// File: rtl/sel_fifo.sv
// -----------------------------------------------------------------------------
// sel_fifo
// Parameterised synchronous FIFO with extended pointers.
//   clock   : rising-edge clock
//   rst_n   : asynchronous active-low reset (empties the FIFO)
//   push_i  : write wdata_i at the tail (ignored when full unless pop_i)
//   wdata_i : data to write
//   pop_i   : advance the head (ignored when empty)
//   rdata_o : current head entry (valid when !empty_o)
//   full_o  : DEPTH entries held
//   empty_o : no entries held
// Pointers carry one extra bit so that full and empty are told apart by the
// MSB; they wrap modulo 2*DEPTH, which requires DEPTH to be a power of two.
// A push while full is honoured when a pop happens in the same cycle: the
// pop frees the head slot, which is exactly the slot the tail points at.
// There is no write-to-read bypass; a pushed entry shows on rdata_o the
// cycle after the write.
// -----------------------------------------------------------------------------
module sel_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sel_sequencer.sv
// -----------------------------------------------------------------------------
// sel_sequencer
// Buffers selector commands and replays each selector for count+1 beats
// towards the selector-decoded register stage.
//   clock       : rising-edge clock
//   rst_n       : asynchronous active-low reset, clears everything at once
//   cmd_valid   : command offered
//   cmd_sel     : selector code of the command
//   cmd_count   : extra beats (0 -> 1 beat, 15 -> 16 beats)
//   cmd_ready   : command FIFO has room
//   sel_valid   : sel_out carries a beat
//   sel_out     : selector to the downstream stage (0 when not valid)
//   sel_ready   : downstream takes the current beat
//   busy        : FIFO non-empty or FSM not IDLE
//   err_illegal : sticky, an illegal selector was received
//   drop_cnt    : dropped illegal commands, saturating at 255
//   dbg_state   : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid never depends on ready; once sel_valid is high it and sel_out stay
// stable until the beat is taken. cmd_ready comes only from FIFO occupancy,
// so a full FIFO refuses even illegal commands until space frees up.
// -----------------------------------------------------------------------------
module sel_sequencer
    import sel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              cmd_ready,
    output logic              sel_valid,
    output logic [SEL_W-1:0]  sel_out,
    input  logic              sel_ready,
    output logic              busy,
    output logic              err_illegal,
    output logic [DROP_W-1:0] drop_cnt,
    output sel_state_t        dbg_state
);

    sel_state_t        state_q, state_d;
    logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
    logic [CNT_W-1:0]  cur_cnt_q, cur_cnt_d;
    logic              err_q, err_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    sel_cmd_t push_cmd;
    sel_cmd_t head_cmd;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    logic     cmd_fire;
    logic     cmd_drop;

    // Input side: illegal codes are taken off the bus but never stored.
    assign cmd_ready = !fifo_full;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign fifo_push = cmd_fire && sel_is_legal(cmd_sel);
    assign cmd_drop  = cmd_fire && !sel_is_legal(cmd_sel);
    assign push_cmd  = '{sel: cmd_sel, count: cmd_count};

    sel_fifo #(
        .W     ($bits(sel_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (push_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sequencer FSM. The "next command" decision is folded into the last
    // beat of ISSUE: when that beat is taken and the FIFO has an entry, the
    // head is loaded on the same edge so beats continue without a bubble.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        cur_cnt_d = cur_cnt_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cur_sel_d = head_cmd.sel;
                    cur_cnt_d = head_cmd.count;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_ready) begin
                    if (cur_cnt_q == '0) begin
                        if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            cur_sel_d = head_cmd.sel;
                            cur_cnt_d = head_cmd.count;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cur_cnt_d = cur_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
            cur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            cur_cnt_q <= cur_cnt_d;
        end
    end

    // Statistics for dropped illegal commands.
    always_comb begin
        err_d  = err_q;
        drop_d = drop_q;
        if (cmd_drop) begin
            err_d = 1'b1;
            if (drop_q != DROP_MAX) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign sel_valid   = (state_q == ISSUE);
    assign sel_out     = sel_valid ? cur_sel_q : '0;
    assign busy        = !fifo_empty || (state_q != IDLE);
    assign err_illegal = err_q;
    assign drop_cnt    = drop_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sel_sequencer
// Directed bench for sel_sequencer: reset values, single and back-to-back
// commands, backpressure, full FIFO, illegal filtering, reset mid-command.
// -----------------------------------------------------------------------------
module tb_sel_sequencer;
    import sel_pkg::*;

    logic              clock;
    logic              rst_n;
    logic              cmd_valid;
    logic [SEL_W-1:0]  cmd_sel;
    logic [CNT_W-1:0]  cmd_count;
    logic              cmd_ready;
    logic              sel_valid;
    logic [SEL_W-1:0]  sel_out;
    logic              sel_ready;
    logic              busy;
    logic              err_illegal;
    logic [DROP_W-1:0] drop_cnt;
    sel_state_t        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [SEL_W-1:0] exp_q[$];
    logic [SEL_W-1:0] got_q[$];
    logic             hold_prev = 1'b0;
    logic [SEL_W-1:0] hold_sel  = '0;

    sel_sequencer #(.DEPTH(4)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_sel     (cmd_sel),
        .cmd_count   (cmd_count),
        .cmd_ready   (cmd_ready),
        .sel_valid   (sel_valid),
        .sel_out     (sel_out),
        .sel_ready   (sel_ready),
        .busy        (busy),
        .err_illegal (err_illegal),
        .drop_cnt    (drop_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Beat monitor on the falling edge: records accepted beats and checks
    // that a stalled beat is held unchanged.
    always @(negedge clock) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", sel_valid, 1);
                check("hold_sel", sel_out, hold_sel);
            end
            if (sel_valid && sel_ready) got_q.push_back(sel_out);
            hold_prev = sel_valid && !sel_ready;
            hold_sel  = sel_out;
        end
    end

    task automatic check_beats(input string tag);
        check({tag, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_sel"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [SEL_W-1:0] s, input logic [CNT_W-1:0] c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_count = c;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_wait", (n < 50), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_count = '0;
        sel_ready = 1'b0;
        repeat (2) tick();

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_sel_out", sel_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_illegal, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();

        // Single command {5,2}: 3 beats, first valid in the cycle after N+1.
        sel_ready = 1'b1;
        push(3'd5, 4'd2);
        check("single_lat_valid", sel_valid, 0);
        check("single_lat_busy", busy, 1);
        tick();
        check("single_b0", sel_out, 5);
        check("single_v0", sel_valid, 1);
        tick();
        check("single_b1", sel_out, 5);
        tick();
        check("single_b2", sel_out, 5);
        tick();
        check("single_end_valid", sel_valid, 0);
        check("single_end_busy", busy, 0);
        repeat (3) exp_q.push_back(3'd5);
        check_beats("single");

        // Back-to-back {1,0},{3,1},{6,0}: beats 1,3,3,6 with no bubble.
        push(3'd1, 4'd0);
        push(3'd3, 4'd1);
        push(3'd6, 4'd0);
        check("b2b_c0", sel_out, 3);
        tick();
        check("b2b_c1", sel_out, 3);
        tick();
        check("b2b_c2", sel_out, 6);
        check("b2b_v2", sel_valid, 1);
        tick();
        check("b2b_end", sel_valid, 0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd6);
        check_beats("b2b");

        // Backpressure on {4,1}: stall 5 cycles after the first beat.
        sel_ready = 1'b0;
        push(3'd4, 4'd1);
        check("bp_idle", sel_valid, 0);
        tick();
        check("bp_first", sel_out, 4);
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        check("bp_after_b1", sel_out, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stall_valid", sel_valid, 1);
            check("bp_stall_sel", sel_out, 4);
        end
        sel_ready = 1'b1;
        tick();
        check("bp_end_valid", sel_valid, 0);
        check("bp_end_busy", busy, 0);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd4);
        check_beats("bp");

        // Full FIFO: 1 held in the FSM plus 4 buffered, then cmd_ready falls.
        sel_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(3'(i), 4'd0);
        end
        check("full_ready", cmd_ready, 0);
        check("full_sel", sel_out, 0);
        check("full_busy", busy, 1);
        cmd_valid = 1'b1;
        cmd_sel   = 3'd5;
        cmd_count = 4'd0;
        tick();
        check("full_refused", cmd_ready, 0);
        sel_ready = 1'b1;
        tick();
        check("full_reopen", cmd_ready, 1);
        check("full_s1", sel_out, 1);
        tick();
        cmd_valid = 1'b0;
        check("full_s2", sel_out, 2);
        check("full_ready2", cmd_ready, 1);
        tick();
        check("full_s3", sel_out, 3);
        tick();
        check("full_s4", sel_out, 4);
        tick();
        check("full_s5", sel_out, 5);
        tick();
        check("full_end_valid", sel_valid, 0);
        check("full_end_busy", busy, 0);
        for (int i = 0; i < 6; i++) exp_q.push_back(3'(i));
        check_beats("full");

        // Illegal filtering: {7,3} dropped, {0,0} gives one beat.
        push(3'd7, 4'd3);
        check("ill_err", err_illegal, 1);
        check("ill_drop1", drop_cnt, 1);
        check("ill_busy", busy, 0);
        check("ill_valid", sel_valid, 0);
        push(3'd0, 4'd0);
        check("ill_lat", sel_valid, 0);
        tick();
        check("ill_beat_v", sel_valid, 1);
        check("ill_beat_s", sel_out, 0);
        tick();
        check("ill_end", sel_valid, 0);
        exp_q.push_back(3'd0);
        check_beats("ill");

        // 300 more illegal pushes: counter saturates at 255.
        cmd_valid = 1'b1;
        cmd_sel   = 3'd7;
        cmd_count = 4'd3;
        repeat (253) tick();
        check("sat_254", drop_cnt, 254);
        repeat (47) tick();
        cmd_valid = 1'b0;
        check("sat_255", drop_cnt, 255);
        check("sat_err", err_illegal, 1);
        check("sat_busy", busy, 0);
        check_beats("sat");

        // Reset mid-command {2,3} after two accepted beats.
        push(3'd2, 4'd3);
        tick();
        check("mid_v", sel_out, 2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", sel_valid, 0);
        check("mid_rst_sel", sel_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_err", err_illegal, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_state", dbg_state, IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", sel_valid, 0);
        check("post_rst_busy", busy, 0);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        check_beats("mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
